a2d_arbiter: RTL and testbench
==============================

Name: a2d_arbiter

Overview:
- Shares the single A2D SPI interface (strt_cnv/chnnl/cnv_cmplt/res) between two requesters.
  - Port 0: motion/IR sensing.
  - Port 1: auxiliary, e.g. battery monitor.
- Latches requests, grants round-robin, issues one conversion at a time and returns each result to its owner with a completion pulse.
- Optional watchdog prevents a lost cnv_cmplt from hanging the controller.

Parameters:
- TIMEOUT_CYC, 1024, clk cycles allowed in WAIT before the conversion is abandoned; must exceed worst-case conversion time.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_strt  in  1  one-cycle conversion request, requester 0
- req0_chnnl  in  3  channel for requester 0, sampled with req0_strt
- req0_cmplt  out  1  one-cycle pulse: req0_res valid
- req0_res  out  12  last result for requester 0
- req1_strt  in  1  one-cycle conversion request, requester 1
- req1_chnnl  in  3  channel for requester 1, sampled with req1_strt
- req1_cmplt  out  1  one-cycle pulse: req1_res valid
- req1_res  out  12  last result for requester 1
- strt_cnv  out  1  to A2D interface, one-cycle start
- chnnl  out  3  to A2D interface, channel of granted request
- cnv_cmplt  in  1  from A2D interface, conversion done
- A2D_res  in  12  from A2D interface, conversion result
- busy  out  1  state != IDLE or any request pending
- timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clock/reset: single clock clk; rst_n asynchronous, active-low. All state is cleared immediately on rst_n low.
- Reset values:
  - All outputs 0; req0_res = req1_res = 12'h000.
  - Pending bits and latched channels 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Request capture:
  - reqN_strt high at a rising edge sets pendN and latches reqN_chnnl into chN.
  - reqN_strt while pendN is set or requester N is in service is ignored: the first channel is kept and no second conversion is queued.
  - Exception: a set on the same edge that pendN clears (completion) wins; the request is accepted as new.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if pend0 or pend1, grant. With both pending, grant the requester != last_grant. Latch grant, drive chnnl = ch[grant], go ISSUE.
  - ISSUE: strt_cnv = 1 for exactly this cycle; go WAIT.
  - WAIT: on cnv_cmplt:
    - res[grant] <= A2D_res;
    - cmplt[grant] pulses high the following cycle, coincident with the new res value;
    - pend[grant] clears; last_grant <= grant; go IDLE.
- chnnl holds the granted channel from the ISSUE cycle through the WAIT exit cycle, then returns to 0 in IDLE with nothing pending.
- cnv_cmplt is ignored in IDLE and ISSUE.
- Latency: reqN_strt at cycle 0 -> pend visible cycle 1 -> strt_cnv high cycle 2. cnv_cmplt sampled at cycle k -> reqN_cmplt high cycle k+1.
- Back-to-back: the next grant issues strt_cnv 2 cycles after leaving WAIT. Two pending requests alternate strictly.
- Width rules: results are stored unmodified, 12-bit unsigned. No arithmetic on the datapath.
- Reset mid-conversion: returns to IDLE and drops pending requests. A cnv_cmplt arriving after reset is ignored.

Optional Feature:
- Macro: A2D_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs only in WAIT and clears on entry.
  - When it reaches TIMEOUT_CYC-1 without cnv_cmplt: timeout_err pulses 1 cycle; reqN_res <= 12'hFFF; reqN_cmplt pulses; pend clears; last_grant updates; go IDLE.
  - cnv_cmplt on the expiry cycle takes priority (normal completion, no error).
- Undefined: no counter; WAIT lasts indefinitely; timeout_err tied 0.

Decomposition:
- Package a2d_arb_pkg:
  - state_t enum (IDLE, ISSUE, WAIT);
  - localparams RES_W = 12, CH_W = 3;
  - TO_RES = 12'hFFF.
- Sub-module a2d_wdog: watchdog counter, with ports clk, rst_n, clr, en, expire. Instantiated only under A2D_ARB_TIMEOUT_EN.

Test Plan:
- Single request: req0_strt, req0_chnnl = 3'd4 -> strt_cnv cycle 2 with chnnl = 4; cnv_cmplt with A2D_res = 12'hA5C -> next cycle req0_cmplt = 1, req0_res = 12'hA5C, req1_cmplt = 0.
- Tie after reset: req0 (ch 1) and req1 (ch 6) pulsed together -> ch 1 converted first, then ch 6. Repeat the tie -> alternation continues (req0 then req1, from last_grant).
- Duplicate request: req1_strt ch 2, then req1_strt ch 5 during WAIT -> exactly one conversion on ch 2; one req1_cmplt.
- Set-vs-clear: req0_strt on the completion edge -> req0_cmplt pulse, then a second strt_cnv for req0 2 cycles after returning to IDLE.
- Timeout (macro on, TIMEOUT_CYC = 16): withhold cnv_cmplt -> timeout_err and req0_cmplt pulse together, req0_res = 12'hFFF, FSM IDLE. Macro off: busy stays 1 indefinitely.
- Reset in WAIT: rst_n low mid-conversion -> all outputs 0 immediately; a later cnv_cmplt produces no cmplt pulse.

Source files
------------

// File: rtl/a2d_arb_pkg.sv
// Shared types and constants for the two-port A2D arbiter.
package a2d_arb_pkg;

  localparam int RES_W = 12;
  localparam int CH_W  = 3;

  // Result reported to a requester whose conversion was abandoned by the watchdog.
  localparam logic [RES_W-1:0] TO_RES = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/a2d_wdog.sv
// Watchdog for the arbiter's WAIT state: counts cycles while enabled and flags
// expiry on the TIMEOUT_CYC-th consecutive enabled cycle. Used only under A2D_ARB_TIMEOUT_EN.
module a2d_wdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Holds at LAST once expired so a stalled consumer never sees a wrapped count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D SPI interface between two requesters.
// Optional watchdog on the WAIT state is enabled with `define A2D_ARB_TIMEOUT_EN.
//
// Handshake: reqN_strt is a one-cycle request sampled with reqN_chnnl; the
// arbiter answers with a one-cycle reqN_cmplt, and reqN_res is valid from that
// cycle until the next completion. Toward the A2D, strt_cnv is a one-cycle
// start and cnv_cmplt is honoured only while waiting for that conversion.
module a2d_arbiter
  import a2d_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_strt,
  input  logic [CH_W-1:0]  req0_chnnl,
  output logic             req0_cmplt,
  output logic [RES_W-1:0] req0_res,
  input  logic             req1_strt,
  input  logic [CH_W-1:0]  req1_chnnl,
  output logic             req1_cmplt,
  output logic [RES_W-1:0] req1_res,
  output logic             strt_cnv,
  output logic [CH_W-1:0]  chnnl,
  input  logic             cnv_cmplt,
  input  logic [RES_W-1:0] A2D_res,
  output logic             busy,
  output logic             timeout_err,
  output state_t           state_dbg
);

  state_t           state, state_nxt;
  logic             pend0, pend1;
  logic [CH_W-1:0]  ch0, ch1;
  logic             grant, grant_nxt, last_grant;
  logic             expire, done;
  logic             clr0, clr1, acc0, acc1;
  logic [RES_W-1:0] done_res;

`ifdef A2D_ARB_TIMEOUT_EN
  a2d_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == ISSUE),
    .en     (state == WAIT),
    .expire (expire)
  );

  // A real completion on the expiry cycle wins, so no error is flagged then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == WAIT) && expire && !cnv_cmplt;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done     = (state == WAIT) && (cnv_cmplt || expire);
  assign done_res = cnv_cmplt ? A2D_res : TO_RES;
  assign clr0     = done && !grant;
  assign clr1     = done && grant;

  // A request landing on its own completion edge is taken as a fresh one.
  assign acc0 = req0_strt && (!pend0 || clr0);
  assign acc1 = req1_strt && (!pend1 || clr1);

  assign strt_cnv  = (state == ISSUE);
  assign busy      = (state != IDLE) || pend0 || pend1;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          state_nxt = ISSUE;
          grant_nxt = (pend0 && pend1) ? ~last_grant : pend1;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      chnnl      <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (done) begin
        last_grant <= grant;
      end
      if ((state == IDLE) && (state_nxt == ISSUE)) begin
        chnnl <= grant_nxt ? ch1 : ch0;
      end else if (done) begin
        chnnl <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      ch0   <= '0;
      ch1   <= '0;
    end else begin
      pend0 <= acc0 || (pend0 && !clr0);
      pend1 <= acc1 || (pend1 && !clr1);
      if (acc0) ch0 <= req0_chnnl;
      if (acc1) ch1 <= req1_chnnl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_cmplt <= 1'b0;
      req1_cmplt <= 1'b0;
      req0_res   <= '0;
      req1_res   <= '0;
    end else begin
      req0_cmplt <= clr0;
      req1_cmplt <= clr1;
      if (clr0) req0_res <= done_res;
      if (clr1) req1_res <= done_res;
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed self-checking bench for a2d_arbiter; exercises the watchdog when
// compiled with A2D_ARB_TIMEOUT_EN, otherwise checks that WAIT never gives up.
module tb_a2d_arbiter;
  import a2d_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_strt = 1'b0, req1_strt = 1'b0;
  logic [2:0]  req0_chnnl = '0, req1_chnnl = '0;
  logic        req0_cmplt, req1_cmplt;
  logic [11:0] req0_res, req1_res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] A2D_res = '0;
  logic        busy, timeout_err;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;

  a2d_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_strt(req0_strt), .req0_chnnl(req0_chnnl), .req0_cmplt(req0_cmplt), .req0_res(req0_res),
    .req1_strt(req1_strt), .req1_chnnl(req1_chnnl), .req1_cmplt(req1_cmplt), .req1_res(req1_res),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input bit r0, input logic [2:0] c0, input bit r1, input logic [2:0] c1);
    req0_strt = r0; req0_chnnl = c0;
    req1_strt = r1; req1_chnnl = c1;
    tick();
    req0_strt = 1'b0;
    req1_strt = 1'b0;
  endtask

  task automatic wait_strt(input int max_cyc, output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      waited++;
      if (strt_cnv === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Called in the strt_cnv cycle; returns in the cycle the completion pulse is visible.
  task automatic complete(input logic [11:0] r);
    tick();
    cnv_cmplt = 1'b1;
    A2D_res = r;
    tick();
    cnv_cmplt = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (strt_cnv !== 1'b0) begin errors++; $display("FAIL rst_strt got %b exp 0", strt_cnv); end
    checks++; if (chnnl !== 3'd0) begin errors++; $display("FAIL rst_chnnl got %0d exp 0", chnnl); end
    checks++; if ({req0_cmplt, req1_cmplt} !== 2'b00) begin errors++; $display("FAIL rst_cmplt got %b exp 00", {req0_cmplt, req1_cmplt}); end
    checks++; if (req0_res !== 12'h000 || req1_res !== 12'h000) begin errors++; $display("FAIL rst_res got %h/%h exp 000/000", req0_res, req1_res); end
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_busy_to got %b%b exp 00", busy, timeout_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_tie();
    bit seen; int w;
    pulse_req(1'b1, 3'd1, 1'b1, 3'd6);
    wait_strt(20, seen, w);
    checks++; if (!seen || w != 1 || chnnl !== 3'd1) begin errors++; $display("FAIL tie_first got seen=%b w=%0d ch=%0d exp 1/1/1", seen, w, chnnl); end
    complete(12'h111);
    checks++; if ({req0_cmplt, req1_cmplt} !== 2'b10 || req0_res !== 12'h111) begin errors++; $display("FAIL tie_first_done got %b res=%h exp 10 res=111", {req0_cmplt, req1_cmplt}, req0_res); end
    wait_strt(20, seen, w);
    checks++; if (!seen || w != 1 || chnnl !== 3'd6) begin errors++; $display("FAIL tie_second got seen=%b w=%0d ch=%0d exp 1/1/6", seen, w, chnnl); end
    complete(12'h666);
    checks++; if ({req0_cmplt, req1_cmplt} !== 2'b01 || req1_res !== 12'h666) begin errors++; $display("FAIL tie_second_done got %b res=%h exp 01 res=666", {req0_cmplt, req1_cmplt}, req1_res); end
    tick();
    pulse_req(1'b1, 3'd3, 1'b1, 3'd7);
    wait_strt(20, seen, w);
    checks++; if (!seen || chnnl !== 3'd3) begin errors++; $display("FAIL tie2_first got seen=%b ch=%0d exp 1/3", seen, chnnl); end
    complete(12'h333);
    wait_strt(20, seen, w);
    checks++; if (!seen || chnnl !== 3'd7) begin errors++; $display("FAIL tie2_second got seen=%b ch=%0d exp 1/7", seen, chnnl); end
    complete(12'h777);
    checks++; if (req0_res !== 12'h333 || req1_res !== 12'h777) begin errors++; $display("FAIL tie2_res got %h/%h exp 333/777", req0_res, req1_res); end
    tick();
  endtask

  task automatic test_single();
    bit seen; int w;
    req0_strt = 1'b1; req0_chnnl = 3'd4;
    tick();
    req0_strt = 1'b0;
    checks++; if (busy !== 1'b1 || strt_cnv !== 1'b0) begin errors++; $display("FAIL single_c1 got busy=%b strt=%b exp 1/0", busy, strt_cnv); end
    tick();
    checks++; if (strt_cnv !== 1'b1 || chnnl !== 3'd4) begin errors++; $display("FAIL single_strt got strt=%b ch=%0d exp 1/4", strt_cnv, chnnl); end
    // A spurious cnv_cmplt in ISSUE must not finish the conversion.
    cnv_cmplt = 1'b1; A2D_res = 12'h0EE;
    tick();
    cnv_cmplt = 1'b0;
    checks++; if (strt_cnv !== 1'b0 || chnnl !== 3'd4 || req0_cmplt !== 1'b0) begin errors++; $display("FAIL single_wait got strt=%b ch=%0d cmplt=%b exp 0/4/0", strt_cnv, chnnl, req0_cmplt); end
    cnv_cmplt = 1'b1; A2D_res = 12'hA5C;
    tick();
    cnv_cmplt = 1'b0;
    checks++; if (req0_cmplt !== 1'b1 || req0_res !== 12'hA5C || req1_cmplt !== 1'b0) begin errors++; $display("FAIL single_done got %b res=%h r1=%b exp 1 res=a5c r1=0", req0_cmplt, req0_res, req1_cmplt); end
    checks++; if (chnnl !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got ch=%0d busy=%b exp 0/0", chnnl, busy); end
    tick();
    checks++; if (req0_cmplt !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", req0_cmplt); end
    seen = 1'b0; w = 0;
  endtask

  task automatic test_tie_after_req0();
    bit seen; int w;
    pulse_req(1'b1, 3'd4, 1'b1, 3'd2);
    wait_strt(20, seen, w);
    checks++; if (!seen || chnnl !== 3'd2) begin errors++; $display("FAIL tie_rr_first got seen=%b ch=%0d exp 1/2", seen, chnnl); end
    complete(12'h222);
    checks++; if (req1_cmplt !== 1'b1 || req1_res !== 12'h222) begin errors++; $display("FAIL tie_rr_done got %b res=%h exp 1 res=222", req1_cmplt, req1_res); end
    wait_strt(20, seen, w);
    checks++; if (!seen || chnnl !== 3'd4) begin errors++; $display("FAIL tie_rr_second got seen=%b ch=%0d exp 1/4", seen, chnnl); end
    complete(12'h444);
    tick();
  endtask

  task automatic test_duplicate();
    bit seen; int w; int n_strt; int n_cmplt;
    pulse_req(1'b0, 3'd0, 1'b1, 3'd2);
    wait_strt(20, seen, w);
    checks++; if (!seen || chnnl !== 3'd2) begin errors++; $display("FAIL dup_strt got seen=%b ch=%0d exp 1/2", seen, chnnl); end
    tick();
    pulse_req(1'b0, 3'd0, 1'b1, 3'd5);
    tick();
    cnv_cmplt = 1'b1; A2D_res = 12'h2B2;
    tick();
    cnv_cmplt = 1'b0;
    checks++; if (req1_cmplt !== 1'b1 || req1_res !== 12'h2B2) begin errors++; $display("FAIL dup_done got %b res=%h exp 1 res=2b2", req1_cmplt, req1_res); end
    n_strt = 0; n_cmplt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (strt_cnv === 1'b1) n_strt++;
      if (req1_cmplt === 1'b1) n_cmplt++;
    end
    checks++; if (n_strt != 0 || n_cmplt != 0 || busy !== 1'b0) begin errors++; $display("FAIL dup_extra got strt=%0d cmplt=%0d busy=%b exp 0/0/0", n_strt, n_cmplt, busy); end
  endtask

  task automatic test_set_clear();
    bit seen; int w;
    pulse_req(1'b1, 3'd3, 1'b0, 3'd0);
    wait_strt(20, seen, w);
    tick();
    cnv_cmplt = 1'b1; A2D_res = 12'h3C3;
    req0_strt = 1'b1; req0_chnnl = 3'd7;
    tick();
    cnv_cmplt = 1'b0; req0_strt = 1'b0;
    checks++; if (req0_cmplt !== 1'b1 || req0_res !== 12'h3C3 || busy !== 1'b1) begin errors++; $display("FAIL setclr_done got %b res=%h busy=%b exp 1 res=3c3 busy=1", req0_cmplt, req0_res, busy); end
    wait_strt(20, seen, w);
    checks++; if (!seen || w != 1 || chnnl !== 3'd7) begin errors++; $display("FAIL setclr_reissue got seen=%b w=%0d ch=%0d exp 1/1/7", seen, w, chnnl); end
    complete(12'h7A7);
    checks++; if (req0_cmplt !== 1'b1 || req0_res !== 12'h7A7) begin errors++; $display("FAIL setclr_second got %b res=%h exp 1 res=7a7", req0_cmplt, req0_res); end
    tick();
  endtask

  task automatic test_idle_cmplt();
    cnv_cmplt = 1'b1; A2D_res = 12'hBAD;
    tick();
    cnv_cmplt = 1'b0;
    tick();
    checks++; if ({req0_cmplt, req1_cmplt} !== 2'b00 || req0_res !== 12'h7A7 || busy !== 1'b0) begin errors++; $display("FAIL idle_cmplt got %b res=%h busy=%b exp 00 res=7a7 busy=0", {req0_cmplt, req1_cmplt}, req0_res, busy); end
  endtask

  task automatic test_timeout();
    bit seen; int w; int n;
    pulse_req(1'b1, 3'd5, 1'b0, 3'd0);
    wait_strt(20, seen, w);
`ifdef A2D_ARB_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (timeout_err === 1'b1) break;
    end
    checks++; if (timeout_err !== 1'b1 || n != 17) begin errors++; $display("FAIL to_latency got err=%b n=%0d exp 1/17", timeout_err, n); end
    checks++; if (req0_cmplt !== 1'b1 || req0_res !== 12'hFFF || req1_cmplt !== 1'b0) begin errors++; $display("FAIL to_result got %b res=%h r1=%b exp 1 res=fff r1=0", req0_cmplt, req0_res, req1_cmplt); end
    checks++; if (state_dbg !== IDLE || busy !== 1'b0) begin errors++; $display("FAIL to_state got st=%0d busy=%b exp 0/0", state_dbg, busy); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", timeout_err); end
`else
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy !== 1'b1 || timeout_err !== 1'b0) n++;
    end
    checks++; if (n != 0 || state_dbg !== WAIT) begin errors++; $display("FAIL no_to got bad=%0d st=%0d exp 0/2", n, state_dbg); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif
    seen = 1'b0; w = 0;
  endtask

  task automatic test_reset_in_wait();
    bit seen; int w;
    pulse_req(1'b1, 3'd6, 1'b1, 3'd1);
    wait_strt(20, seen, w);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (strt_cnv !== 1'b0 || chnnl !== 3'd0 || busy !== 1'b0 || state_dbg !== IDLE) begin errors++; $display("FAIL rstw_async got strt=%b ch=%0d busy=%b st=%0d exp 0/0/0/0", strt_cnv, chnnl, busy, state_dbg); end
    checks++; if (req0_res !== 12'h000 || req1_res !== 12'h000) begin errors++; $display("FAIL rstw_res got %h/%h exp 000/000", req0_res, req1_res); end
    tick();
    rst_n = 1'b1;
    tick();
    cnv_cmplt = 1'b1; A2D_res = 12'h5A5;
    tick();
    cnv_cmplt = 1'b0;
    checks++; if ({req0_cmplt, req1_cmplt} !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rstw_late got %b busy=%b exp 00/0", {req0_cmplt, req1_cmplt}, busy); end
    tick();
    checks++; if ({req0_cmplt, req1_cmplt, strt_cnv} !== 3'b000) begin errors++; $display("FAIL rstw_quiet got %b exp 000", {req0_cmplt, req1_cmplt, strt_cnv}); end
  endtask

  initial begin
    #1;
    test_reset();
    test_tie();
    test_single();
    test_tie_after_req0();
    test_duplicate();
    test_set_clear();
    test_idle_cmplt();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got stuck exp finish");
    $fatal(1, "bench time limit");
  end

endmodule
